// File: rtl/button_conditioner_pkg.sv
// Shared constants for the pushbutton/switch conditioner: board clock,
// default and simulation debounce lengths, default counter width.
package button_conditioner_pkg;

    localparam int unsigned CLK_HZ           = 16_000_000;
    // One millisecond of stability at the board clock.
    localparam int unsigned DEBOUNCE_DEFAULT = CLK_HZ / 1000;
    localparam int unsigned DEBOUNCE_SIM     = 4;
    localparam int unsigned CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/debounce_bit.sv
// Single-input conditioner: two-flop synchroniser, stability counter,
// accepted level and a one-cycle pulse on each accepted rising transition.
module debounce_bit
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Any sample that agrees with the accepted level discards progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= s2;
                rise  <= s2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounced level, rise pulse and sticky press events for WIDTH pins.
// Define BUTTON_EVENT_EN to build the event flags, clr_i handling and irq_o.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] event_o,
    input  logic [WIDTH-1:0] clr_i,
    output logic             irq_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk   (CLK),
            .rst   (RST),
            .pin   (pin_i[i]),
            .level (level_o[i]),
            .rise  (rise_o[i])
        );
    end

`ifdef BUTTON_EVENT_EN
    logic [WIDTH-1:0] event_nxt_c;

    // A rise in the same cycle as a clear re-arms the flag.
    assign event_nxt_c = (event_o & ~clr_i) | rise_o;

    always_ff @(posedge CLK) begin
        if (RST) begin
            event_o <= '0;
            irq_o   <= 1'b0;
        end else begin
            event_o <= event_nxt_c;
            irq_o   <= |event_nxt_c;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = ^clr_i;
    assign event_o    = '0;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench for button_conditioner with a short debounce window;
// expectations follow BUTTON_EVENT_EN when it is defined for the build.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned D = DEBOUNCE_SIM;
`ifdef BUTTON_EVENT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] pin;
    logic [W-1:0] clr;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] evt;
    logic         irq;

    always #5 CLK = ~CLK;

    button_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .pin_i   (pin),
        .level_o (level),
        .rise_o  (rise),
        .event_o (evt),
        .clr_i   (clr),
        .irq_o   (irq)
    );

    typedef struct packed {
        logic [W-1:0] level;
        logic [W-1:0] rise;
        logic [W-1:0] evt;
        logic         irq;
    } exp_t;

    exp_t         sb[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           edge_n = 0;

    // Reference: history of pin samples as the counter sees them (index 0 newest).
    logic [W-1:0] sh[D+2];
    logic [W-1:0] m_lvl;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_evt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // Accept when the last D counter-visible samples all differ from the level.
    task automatic step(input logic r, input logic [W-1:0] p, input logic [W-1:0] c);
        exp_t         e;
        exp_t         o;
        logic [W-1:0] flip;
        logic [W-1:0] nevt;
        RST = r;
        pin = p;
        clr = c;
        for (int j = D + 1; j > 0; j--) sh[j] = sh[j-1];
        sh[0] = r ? '0 : p;
        if (r) begin
            sh[1]  = '0;
            m_lvl  = '0;
            m_rise = '0;
            m_evt  = '0;
        end else begin
            nevt = (m_evt & ~c) | m_rise;
            flip = '1;
            for (int j = 2; j <= D + 1; j++) flip &= sh[j] ^ m_lvl;
            m_rise = flip & ~m_lvl;
            m_lvl  = m_lvl ^ flip;
            m_evt  = EV ? nevt : '0;
        end
        e.level = m_lvl;
        e.rise  = m_rise;
        e.evt   = m_evt;
        e.irq   = |m_evt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        edge_n++;
        o = sb.pop_front();
        check_val("level", 32'(level), 32'(o.level));
        check_val("rise",  32'(rise),  32'(o.rise));
        check_val("event", 32'(evt),   32'(o.evt));
        check_val("irq",   32'(irq),   32'(o.irq));
    endtask

    initial begin
        int kd;
        int found;
        int nrise;
        int bnc[5];
        bnc = '{1, 0, 1, 1, 0};
        RST = 1'b1;
        pin = '0;
        clr = '0;
        for (int j = 0; j < D + 2; j++) sh[j] = '0;
        m_lvl  = '0;
        m_rise = '0;
        m_evt  = '0;

        repeat (3) step(1'b1, 4'b0000, 4'b0000);
        check_val("reset_level", 32'(level), 32'd0);

        // Bit 0 press: level and rise appear after edge k+5.
        kd    = edge_n + 1;
        found = -1;
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 4'b0001, 4'b0000);
            if (level[0] && found < 0) found = edge_n - kd;
        end
        check_val("lat_bit0", 32'(found), 32'd5);

        // Bit 1 pulse shorter than the window is rejected.
        repeat (3) step(1'b0, 4'b0011, 4'b0000);
        nrise = 0;
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 4'b0001, 4'b0000);
            nrise += int'(rise[1]);
        end
        check_val("short_pulse_rise1", 32'(nrise), 32'd0);
        check_val("short_pulse_lvl1", 32'(level[1]), 32'd0);

        // Bit 2 bounces, then settles high: exactly one rise.
        nrise = 0;
        for (int j = 0; j < 5; j++) begin
            step(1'b0, (bnc[j] != 0) ? 4'b0101 : 4'b0001, 4'b0000);
            nrise += int'(rise[2]);
        end
        kd    = edge_n + 1;
        found = -1;
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 4'b0101, 4'b0000);
            nrise += int'(rise[2]);
            if (level[2] && found < 0) found = edge_n - kd;
        end
        check_val("bounce_rise_count", 32'(nrise), 32'd1);
        check_val("lat_bit2", 32'(found), 32'd5);

        // Clear bits 0 and 2 so irq reflects bit 3 alone.
        step(1'b0, 4'b0101, 4'b0101);
        step(1'b0, 4'b0101, 4'b0000);

        // Bit 3: press, release, press again with a clear on the rise cycle.
        repeat (8) step(1'b0, 4'b1101, 4'b0000);
        repeat (8) step(1'b0, 4'b0101, 4'b0000);
        repeat (6) step(1'b0, 4'b1101, 4'b0000);
        check_val("rise3_second", 32'(rise[3]), 32'd1);
        step(1'b0, 4'b1101, 4'b1000);
        check_val("evt3_set_wins", 32'(evt[3]), 32'(EV));
        repeat (3) step(1'b0, 4'b1101, 4'b0000);
        step(1'b0, 4'b1101, 4'b1000);
        check_val("evt3_cleared", 32'(evt[3]), 32'd0);
        check_val("irq_cleared", 32'(irq), 32'd0);

        // Release everything, then reset in the middle of a bit 0 count.
        repeat (8) step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b1111);
        repeat (4) step(1'b0, 4'b0001, 4'b0000);
        repeat (2) step(1'b1, 4'b0001, 4'b0000);
        check_val("mid_reset_level", 32'(level), 32'd0);
        kd    = edge_n + 1;
        found = -1;
        nrise = 0;
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 4'b0001, 4'b0000);
            nrise += int'(rise[0]);
            if (level[0] && found < 0) found = edge_n - kd;
        end
        check_val("lat_after_reset", 32'(found), 32'd5);
        check_val("rise_after_reset", 32'(nrise), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
